// File: rtl/stage_pkg.sv
// Stage numbering shared by the stage sequencer and the control unit.
// The control unit decodes these values directly, so they must not be renumbered.
package stage_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    STAGE_FETCH     = 3'd1,
    STAGE_DECODE    = 3'd2,
    STAGE_EXECUTE   = 3'd3,
    STAGE_MEMORY    = 3'd4,
    STAGE_WRITEBACK = 3'd5
  } stage_e;

endpackage

// File: rtl/stage_counter.sv
// Modulo stage sequencer: MIN_STAGE..MAX_STAGE, one step per clk, wraps to MIN_STAGE.
// Latency: out is a plain register, with no input-to-output combinational path.
// Backpressure: none; the counter always advances when reset is low.
module stage_counter
  import stage_pkg::*;
#(
  parameter int WIDTH     = STAGE_W,
  parameter int MIN_STAGE = int'(STAGE_FETCH),
  parameter int MAX_STAGE = int'(STAGE_WRITEBACK)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_STAGE);

  if (MAX_STAGE >= (1 << WIDTH)) begin : g_bad_width
    $error("stage_counter: MAX_STAGE does not fit in WIDTH bits");
  end
  if (MIN_STAGE > MAX_STAGE) begin : g_bad_range
    $error("stage_counter: MIN_STAGE must not exceed MAX_STAGE");
  end
  if (MIN_STAGE < 0) begin : g_bad_min
    $error("stage_counter: MIN_STAGE must be non-negative");
  end

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] stage_d;

  // The last stage and any out-of-range value both land on MIN_STAGE, so the
  // increment can never overflow and there is no lock-up state.
  always_comb begin
    stage_d = MIN_V;
    if (int'(stage_q) >= MIN_STAGE && int'(stage_q) < MAX_STAGE) begin
      stage_d = stage_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= MIN_V;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out = stage_q;

endmodule

// File: tb/tb_stage_counter.sv
// Bench for stage_counter: vector table, corner sequences and a randomized run
// compared against a position-in-cycle model.
module tb_stage_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       reset2;
  logic [2:0] out;
  logic [1:0] out2;

  always #5 clk = ~clk;

  stage_counter dut (
    .clk  (clk),
    .reset(reset),
    .out  (out)
  );

  stage_counter #(
    .WIDTH    (2),
    .MIN_STAGE(0),
    .MAX_STAGE(3)
  ) u_small (
    .clk  (clk),
    .reset(reset2),
    .out  (out2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d at time %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst;
    int   exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int seq[12];
    int edges;
    bit seen_one;
    int k;
    int pos;
    int r;

    reset  = 1'b0;
    reset2 = 1'b1;

    seq = '{2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2, 3};
    for (int i = 0; i < 3; i++) tbl.push_back('{rst: 1'b1, exp: 1});
    for (int i = 0; i < 12; i++) tbl.push_back('{rst: 1'b0, exp: seq[i]});

    // Power-up: reset raised between edges must take effect before any edge.
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("por_async", out, 1);
    check("small_reset", out2, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      @(posedge clk);
      #1 check($sformatf("vec_%0d", i), out, tbl[i].exp);
    end

    // Period between successive stage-1 values.
    edges = 0;
    seen_one = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 edges++;
      if (out === 3'd1) begin
        if (seen_one) check("period", edges, 5);
        seen_one = 1'b1;
        edges = 0;
      end
    end

    // Asynchronous reset in the middle of execute.
    k = 0;
    while (out !== 3'd3 && k < 10) begin
      @(posedge clk);
      #1 k++;
    end
    check("reach_stage3", out, 3);
    #1 reset = 1'b1;
    #1 check("mid_async", out, 1);
    @(posedge clk);
    #1 check("mid_hold", out, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1 check("mid_resume", out, 2);

    // Illegal-value recovery.
    @(negedge clk);
    force dut.stage_q = 3'd0;
    #1 release dut.stage_q;
    @(posedge clk);
    #1 check("illegal_0", out, 1);
    @(negedge clk);
    force dut.stage_q = 3'd6;
    #1 release dut.stage_q;
    @(posedge clk);
    #1 check("illegal_6", out, 1);
    @(negedge clk);
    force dut.stage_q = 3'd7;
    #1 release dut.stage_q;
    @(posedge clk);
    #1 check("illegal_7", out, 1);

    // Randomized run: model is the position within the 5-stage cycle.
    pos = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      reset = (r == 0);
      if (r == 1) begin
        #1 reset = 1'b1;
        #1 check("rand_async", out, 1);
        pos = 0;
        #1 reset = 1'b0;
      end
      @(posedge clk);
      if (reset) pos = 0;
      else pos = (pos + 1) % 5;
      #1 check("rand_seq", out, 1 + pos);
    end
    reset = 1'b0;

    // Overridden range 0..3 on the second instance.
    @(negedge clk);
    check("small_reset_held", out2, 0);
    reset2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check($sformatf("small_seq_%0d", i), out2, (i + 1) % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
